ravenna_timer_multi: RTL and testbench

Multi-channel, parametrised counter/timer peripheral for the Ravenna SoC, sitting on the PicoRV32 memory-mapped register bus alongside the UART and SPI masters. It generalises the single timer to CHANNELS independent channels, each with WIDTH-bit count, an 8-bit prescaler, up/down counting, one-shot or continuous mode, and a sticky per-channel interrupt.

---
 rtl/ravenna_timer_multi_if.sv | 22 ++
 rtl/ravenna_timer_multi.sv | 178 +++++++++++++++++
 tb/tb_ravenna_timer_multi.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ravenna_timer_multi_if.sv
// ravenna_timer_multi_if: register bus between PicoRV32 and the timer block.
// The master drives select/address/data; the slave returns read data and irq.
interface ravenna_timer_multi_if #(
  parameter int CHANNELS = 2
);
  logic [3:0]          reg_sel;
  logic [1:0]          reg_addr;
  logic [3:0]          reg_we;
  logic [31:0]         reg_di;
  logic [31:0]         reg_do;
  logic [CHANNELS-1:0] irq;

  modport master (
    output reg_sel, reg_addr, reg_we, reg_di,
    input  reg_do, irq
  );

  modport slave (
    input  reg_sel, reg_addr, reg_we, reg_di,
    output reg_do, irq
  );
endinterface

// File: rtl/ravenna_timer_multi.sv
// ravenna_timer_multi: CHANNELS x WIDTH-bit prescaled up/down timers.
// Define TIMER_CHAIN_EN to allow channel i to tick on expiry of channel i-1.
module ravenna_timer_multi #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32
) (
  input logic clk,
  input logic reset,
  ravenna_timer_multi_if.slave bus
);
  typedef logic [WIDTH-1:0] cnt_t;

  logic [CHANNELS-1:0] en_q, en_d, os_q, os_d;
  logic [CHANNELS-1:0] up_q, up_d, ie_q, ie_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] chn, tick, expire;
  logic [7:0]  psc_q  [CHANNELS];
  logic [7:0]  psc_d  [CHANNELS];
  logic [7:0]  pcnt_q [CHANNELS];
  logic [7:0]  pcnt_d [CHANNELS];
  cnt_t        val_q  [CHANNELS];
  cnt_t        val_d  [CHANNELS];
  cnt_t        rld_q  [CHANNELS];
  cnt_t        rld_d  [CHANNELS];
  logic [31:0] cfg_w  [CHANNELS];
  logic [31:0] rdata;

`ifdef TIMER_CHAIN_EN
  logic [CHANNELS-1:0] ch_q, ch_d;
  assign chn = ch_q;
`else
  assign chn = '0;
`endif

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] d,
    input logic [3:0]  be
  );
    merge = o;
    for (int b = 0; b < 4; b++)
      if (be[b]) merge[8*b +: 8] = d[8*b +: 8];
  endfunction

  always_comb begin
    for (int i = 0; i < CHANNELS; i++)
      cfg_w[i] = {16'h0, psc_q[i], 3'b0, chn[i],
                  ie_q[i], up_q[i], os_q[i], en_q[i]};
  end

  always_comb begin : next_state
    logic [31:0] nc;
    logic hit, cfg_wr, val_wr, rld_wr, sts_wr;
    logic prev, ptick;
    nc = '0;
    hit = 1'b0;
    cfg_wr = 1'b0;
    val_wr = 1'b0;
    rld_wr = 1'b0;
    sts_wr = 1'b0;
    prev = 1'b0;
    ptick = 1'b0;
    tick = '0;
    expire = '0;
    en_d = en_q;
    os_d = os_q;
    up_d = up_q;
    ie_d = ie_q;
    pend_d = pend_q;
`ifdef TIMER_CHAIN_EN
    ch_d = ch_q;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      hit = (bus.reg_sel == 4'(i)) && (|bus.reg_we);
      cfg_wr = hit && (bus.reg_addr == 2'd0);
      val_wr = hit && (bus.reg_addr == 2'd1);
      rld_wr = hit && (bus.reg_addr == 2'd2);
      sts_wr = hit && (bus.reg_addr == 2'd3);
      nc = merge(cfg_w[i], bus.reg_di, bus.reg_we);
      // a chained channel ticks on its predecessor's expire, same cycle
      prev = (i == 0) ? 1'b0 : expire[(i == 0) ? 0 : i - 1];
      ptick = (pcnt_q[i] == psc_q[i]);
      tick[i] = en_q[i] && (chn[i] ? prev : ptick);
      expire[i] = tick[i] &&
                  (up_q[i] ? (val_q[i] == rld_q[i])
                           : (val_q[i] == '0));

      pcnt_d[i] = (cfg_wr || !en_q[i] || ptick || chn[i])
                ? 8'd0 : pcnt_q[i] + 8'd1;

      psc_d[i] = psc_q[i];
      if (expire[i] && os_q[i]) en_d[i] = 1'b0;
      if (cfg_wr) begin
        en_d[i]  = nc[0];
        os_d[i]  = nc[1];
        up_d[i]  = nc[2];
        ie_d[i]  = nc[3];
        psc_d[i] = nc[15:8];
`ifdef TIMER_CHAIN_EN
        ch_d[i]  = (i != 0) && nc[4];
`endif
      end

      val_d[i] = val_q[i];
      if (val_wr) begin
        val_d[i] = cnt_t'(merge(32'(val_q[i]),
                                bus.reg_di, bus.reg_we));
      end else if (tick[i]) begin
        if (!expire[i])
          val_d[i] = up_q[i] ? val_q[i] + cnt_t'(1)
                             : val_q[i] - cnt_t'(1);
        else if (!os_q[i])
          val_d[i] = up_q[i] ? '0 : rld_q[i];
      end

      rld_d[i] = rld_wr
               ? cnt_t'(merge(32'(rld_q[i]),
                              bus.reg_di, bus.reg_we))
               : rld_q[i];

      if (expire[i])
        pend_d[i] = 1'b1;
      else if (sts_wr && bus.reg_we[0] && bus.reg_di[0])
        pend_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q   <= '0;
      os_q   <= '0;
      up_q   <= '0;
      ie_q   <= '0;
      pend_q <= '0;
`ifdef TIMER_CHAIN_EN
      ch_q   <= '0;
`endif
      for (int i = 0; i < CHANNELS; i++) begin
        psc_q[i]  <= '0;
        pcnt_q[i] <= '0;
        val_q[i]  <= '0;
        rld_q[i]  <= '0;
      end
    end else begin
      en_q   <= en_d;
      os_q   <= os_d;
      up_q   <= up_d;
      ie_q   <= ie_d;
      pend_q <= pend_d;
`ifdef TIMER_CHAIN_EN
      ch_q   <= ch_d;
`endif
      for (int i = 0; i < CHANNELS; i++) begin
        psc_q[i]  <= psc_d[i];
        pcnt_q[i] <= pcnt_d[i];
        val_q[i]  <= val_d[i];
        rld_q[i]  <= rld_d[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.reg_sel == 4'(i)) begin
        unique case (bus.reg_addr)
          2'd0: rdata = cfg_w[i];
          2'd1: rdata = 32'(val_q[i]);
          2'd2: rdata = 32'(rld_q[i]);
          2'd3: rdata = {31'h0, pend_q[i]};
        endcase
      end
    end
  end

  assign bus.reg_do = rdata;
  assign bus.irq    = pend_q & ie_q;
endmodule

// File: tb/tb_ravenna_timer_multi.sv
// tb_ravenna_timer_multi: register vectors plus timing sequences
// for a 2x32 instance and a 1x8 instance.
module tb_ravenna_timer_multi;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ravenna_timer_multi_if #(.CHANNELS(2)) bus ();
  ravenna_timer_multi_if #(.CHANNELS(1)) bus8 ();

  ravenna_timer_multi #(.CHANNELS(2), .WIDTH(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  ravenna_timer_multi #(.CHANNELS(1), .WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [3:0]  sel;
    logic [1:0]  addr;
    logic [3:0]  we;
    logic [31:0] di;
    logic [3:0]  rsel;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[10];

  int passed = 0;
  int total = 0;
  int n;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
  endtask

  task automatic drive(input int t, input logic [3:0] sel,
                       input logic [1:0] addr, input logic [3:0] we,
                       input logic [31:0] di);
    if (t == 0) begin
      bus.reg_sel = sel; bus.reg_addr = addr;
      bus.reg_we = we;   bus.reg_di = di;
    end else begin
      bus8.reg_sel = sel; bus8.reg_addr = addr;
      bus8.reg_we = we;   bus8.reg_di = di;
    end
  endtask

  task automatic wr(input int t, input logic [3:0] sel,
                    input logic [1:0] addr, input logic [31:0] di,
                    input logic [3:0] we = 4'hF);
    @(negedge clk);
    drive(t, sel, addr, we, di);
    @(posedge clk);
    #1;
    drive(t, sel, addr, 4'h0, 32'h0);
  endtask

  task automatic rd(input string nm, input int t, input logic [3:0] sel,
                    input logic [1:0] addr, input logic [31:0] exp);
    sb_t s;
    logic [31:0] act;
    drive(t, sel, addr, 4'h0, 32'h0);
    sbq.push_back('{nm, exp});
    #1;
    act = (t == 0) ? bus.reg_do : bus8.reg_do;
    s = sbq.pop_front();
    check(s.name, act, s.exp);
  endtask

  task automatic wait_irq(input int b, input int maxc, output int cyc);
    cyc = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(posedge clk);
      #1;
      if (bus.irq[b]) begin
        cyc = k;
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    drive(0, 4'h0, 2'h0, 4'h0, 32'h0);
    drive(1, 4'h0, 2'h0, 4'h0, 32'h0);

    vt[0] = '{4'd0, 2'd2, 4'hF, 32'hDEADBEEF, 4'd0, 2'd2, 32'hDEADBEEF};
    vt[1] = '{4'd0, 2'd2, 4'h2, 32'h00005500, 4'd0, 2'd2, 32'hDEAD55EF};
    vt[2] = '{4'd2, 2'd2, 4'hF, 32'h12345678, 4'd0, 2'd2, 32'hDEAD55EF};
    vt[3] = '{4'd2, 2'd2, 4'h0, 32'h0,        4'd2, 2'd2, 32'h0};
    vt[4] = '{4'd15, 2'd0, 4'h0, 32'h0,       4'd15, 2'd0, 32'h0};
`ifdef TIMER_CHAIN_EN
    vt[5] = '{4'd1, 2'd0, 4'hF, 32'hFFFFFFF6, 4'd1, 2'd0, 32'h0000FF16};
`else
    vt[5] = '{4'd1, 2'd0, 4'hF, 32'hFFFFFFF6, 4'd1, 2'd0, 32'h0000FF06};
`endif
    vt[6] = '{4'd0, 2'd0, 4'hF, 32'h00000010, 4'd0, 2'd0, 32'h0};
    vt[7] = '{4'd1, 2'd1, 4'hF, 32'hCAFEF00D, 4'd1, 2'd1, 32'hCAFEF00D};
    vt[8] = '{4'd0, 2'd1, 4'h8, 32'hAB000000, 4'd0, 2'd1, 32'hAB000000};
    vt[9] = '{4'd1, 2'd0, 4'h1, 32'h0,        4'd1, 2'd0, 32'h0000FF00};

    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4; a++) begin
        @(negedge clk);
        rd($sformatf("reset ch%0d r%0d", s, a), 0, 4'(s), 2'(a), 32'h0);
      end
    check("reset irq", 32'(bus.irq), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wr(0, 0, 0, 32'h0000000F);
    rd("cfg before reset", 0, 0, 0, 32'h0000000F);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    rd("cfg after reset", 0, 0, 0, 32'h0);
    rd("status after reset", 0, 0, 3, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (vt[i].we != 4'h0)
        wr(0, vt[i].sel, vt[i].addr, vt[i].di, vt[i].we);
      else
        @(negedge clk);
      rd($sformatf("vec%0d", i), 0, vt[i].rsel, vt[i].raddr, vt[i].exp);
    end
    wr(0, 1, 0, 32'h0);
    wr(0, 1, 1, 32'h0);
    wr(0, 0, 2, 32'h0);
    wr(0, 0, 1, 32'h0);

    wr(0, 0, 1, 32'd4);
    wr(0, 0, 2, 32'd4);
    wr(0, 0, 0, 32'h00000309);
    wait_irq(0, 40, n);
    check("ch0 first irq cycles", 32'(n), 32'd20);
    rd("ch0 pending", 0, 0, 3, 32'h1);
    wr(0, 0, 3, 32'h1);
    check("ch0 irq after w1c", 32'(bus.irq[0]), 32'h0);
    rd("ch0 status after w1c", 0, 0, 3, 32'h0);
    wait_irq(0, 40, n);
    check("ch0 second irq cycles", 32'(n), 32'd19);
    wr(0, 0, 0, 32'h0);
    wr(0, 0, 3, 32'h1);

    wr(0, 1, 2, 32'd9);
    wr(0, 1, 1, 32'd0);
    wr(0, 1, 0, 32'h00000007);
    repeat (9) @(posedge clk);
    #1;
    rd("ch1 value at 9", 0, 1, 1, 32'd9);
    rd("ch1 not yet pending", 0, 1, 3, 32'h0);
    @(posedge clk);
    #1;
    rd("ch1 pending", 0, 1, 3, 32'h1);
    rd("ch1 oneshot cfg", 0, 1, 0, 32'h00000006);
    rd("ch1 held value", 0, 1, 1, 32'd9);
    check("ch1 irq masked", 32'(bus.irq[1]), 32'h0);
    wr(0, 1, 3, 32'h1);

    wr(0, 0, 2, 32'd5);
    wr(0, 0, 1, 32'd3);
    wr(0, 0, 0, 32'h00000001);
    repeat (3) @(posedge clk);
    wr(0, 0, 3, 32'h1);
    rd("w1c vs expire", 0, 0, 3, 32'h1);
    rd("ch0 reloaded", 0, 0, 1, 32'd5);
    wr(0, 0, 1, 32'h00000100);
    rd("value write vs tick", 0, 0, 1, 32'h00000100);
    @(posedge clk);
    #1;
    rd("ch0 after write", 0, 0, 1, 32'h000000FF);
    wr(0, 0, 0, 32'h0);
    wr(0, 0, 3, 32'h1);

    wr(0, 1, 2, 32'd2);
    wr(0, 1, 1, 32'd0);
    wr(0, 1, 0, 32'h00000007);
    repeat (2) @(posedge clk);
    wr(0, 1, 0, 32'h00000007);
    rd("cfg write vs oneshot", 0, 1, 0, 32'h00000007);
    wr(0, 1, 0, 32'h0);
    wr(0, 1, 3, 32'h1);

    wr(0, 1, 2, 32'd2);
    wr(0, 1, 1, 32'd2);
    wr(0, 0, 2, 32'd1);
    wr(0, 0, 1, 32'd1);
    wr(0, 1, 0, 32'h00000019);
`ifdef TIMER_CHAIN_EN
    rd("ch1 chain cfg", 0, 1, 0, 32'h00000019);
    wr(0, 0, 0, 32'h00000001);
    wait_irq(1, 40, n);
    check("chain first expire", 32'(n), 32'd6);
    wr(0, 1, 3, 32'h1);
    wait_irq(1, 40, n);
    check("chain period", 32'(n), 32'd5);
`else
    rd("ch1 chain cfg", 0, 1, 0, 32'h00000009);
    wait_irq(1, 40, n);
    check("unchained first expire", 32'(n), 32'd3);
    wr(0, 1, 3, 32'h1);
    wait_irq(1, 40, n);
    check("unchained period", 32'(n), 32'd2);
`endif
    wr(0, 0, 0, 32'h0);
    wr(0, 1, 0, 32'h0);

    wr(1, 0, 1, 32'h00001234);
    rd("w8 value trunc", 1, 0, 1, 32'h00000034);
    wr(1, 0, 2, 32'h00000010);
    wr(1, 0, 1, 32'h000000FF);
    wr(1, 0, 0, 32'h00000005);
    @(posedge clk);
    #1;
    rd("w8 wrap", 1, 0, 1, 32'h0);
    repeat (16) @(posedge clk);
    #1;
    rd("w8 at terminal", 1, 0, 1, 32'h00000010);
    rd("w8 not pending", 1, 0, 3, 32'h0);
    @(posedge clk);
    #1;
    rd("w8 pending", 1, 0, 3, 32'h1);
    rd("w8 restart", 1, 0, 1, 32'h0);
    check("w8 irq masked", 32'(bus8.irq), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
